// File: rtl/img_pkg.sv
// Shared widths, scan states and record layouts for the raster pixel scanner.
package img_pkg;

  localparam int COORD_W = 10;
  localparam int ADDR_W  = 17;
  localparam int PIX_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [ADDR_W-1:0]  addr;
  } pix_meta_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [ADDR_W-1:0]  addr;
    logic [PIX_W-1:0]   pixel;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead synchronous FIFO: dout presents the oldest entry whenever !empty.
module pixel_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pixel_scan_ctrl.sv
// Raster scan sequencer: issues pixel-memory reads, tags returning data with
// (x, y, addr) and queues it for the downstream pipeline under credit control.
module pixel_scan_ctrl
  import img_pkg::*;
#(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [PIX_W-1:0]   mem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [PIX_W-1:0]   out_pixel
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  scan_state_t        state;
  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic [ADDR_W-1:0]  addr_cnt;
  logic [COORD_W-1:0] rd_x, rd_y;
  logic [CNT_W-1:0]   outstanding;

  logic [COORD_W-1:0] cur_x, cur_y;
  logic [ADDR_W-1:0]  cur_addr;
  logic               last_col, last_pix;
  logic               issue, pop, room;

  logic [MEM_LAT-1:0] d_valid;
  pix_meta_t          d_meta [MEM_LAT];

  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_fifo_count;
  fifo_entry_t        head;
  fifo_entry_t        wr_entry;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees a credit, which keeps the pipe full at 1 pixel/cycle.
  assign room      = (outstanding < CNT_W'(FIFO_DEPTH)) || pop;
  assign unused_fifo_count = ^fifo_count;

  always_comb begin
    cur_x    = x_cnt;
    cur_y    = y_cnt;
    cur_addr = addr_cnt;
    if (state == IDLE) begin
      cur_x    = '0;
      cur_y    = '0;
      cur_addr = '0;
    end
    last_col = (cur_x == COORD_W'(IMG_W - 1));
    last_pix = last_col && (cur_y == COORD_W'(IMG_H - 1));
    issue    = 1'b0;
    if (!abort) begin
      if (state == IDLE)      issue = start;
      else if (state == SCAN) issue = room;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      rd_x        <= '0;
      rd_y        <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      addr_cnt    <= '0;
      outstanding <= '0;
    end else begin
      mem_rd <= issue;
      done   <= 1'b0;
      if (issue) begin
        mem_addr <= cur_addr;
        rd_x     <= cur_x;
        rd_y     <= cur_y;
        x_cnt    <= last_col ? '0 : cur_x + 1'b1;
        y_cnt    <= last_col ? cur_y + 1'b1 : cur_y;
        addr_cnt <= cur_addr + 1'b1;
      end
      if (issue && !pop)      outstanding <= outstanding + 1'b1;
      else if (pop && !issue) outstanding <= outstanding - 1'b1;

      case (state)
        IDLE: begin
          if (issue) begin
            state <= last_pix ? DRAIN : SCAN;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (issue && last_pix) state <= DRAIN;
        end
        DRAIN: begin
          if (outstanding == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag pipeline matching the fixed memory read latency.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      d_valid <= '0;
    end else begin
      d_valid[0] <= mem_rd;
      for (int i = 1; i < MEM_LAT; i++) d_valid[i] <= d_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    d_meta[0] <= '{x: rd_x, y: rd_y, addr: mem_addr};
    for (int i = 1; i < MEM_LAT; i++) d_meta[i] <= d_meta[i-1];
  end

  assign wr_entry = '{x:     d_meta[MEM_LAT-1].x,
                      y:     d_meta[MEM_LAT-1].y,
                      addr:  d_meta[MEM_LAT-1].addr,
                      pixel: mem_data};

  pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (d_valid[MEM_LAT-1]),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_x     = out_valid ? head.x     : '0;
  assign out_y     = out_valid ? head.y     : '0;
  assign out_addr  = out_valid ? head.addr  : '0;
  assign out_pixel = out_valid ? head.pixel : '0;

endmodule
